// File: rtl/key_pulse_gen_pkg.sv
// Shared definitions for key_pulse_gen: key channel indices, channel FSM
// state encoding and the counter sizing helper.
package key_pulse_gen_pkg;

  localparam int KEY_UP    = 0;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_LEFT  = 2;
  localparam int KEY_RIGHT = 3;
  localparam int KEY_EXIT  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
  } chan_state_e;

  // One spare bit above the largest compared value so saturation never aliases it.
  function automatic int cntWidth(input int maxValue);
    return $clog2(maxValue) + 1;
  endfunction

endpackage

// File: rtl/key_channel.sv
// One push-button channel: 2-flop synchronizer, debounce filter, and the
// press/auto-repeat FSM producing single-cycle pulses.
module key_channel
  import key_pulse_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  input  logic i_repeat_en,
  output logic o_level,
  output logic o_pulse
);

  localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? (REPEAT_DELAY - 1) : (REPEAT_PERIOD - 1);
  localparam int DEB_W   = cntWidth(DEBOUNCE_CYCLES - 1);
  localparam int TMR_W   = cntWidth(TMR_MAX);

  localparam logic [DEB_W-1:0] DEB_LAST    = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] DELAY_LAST  = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'(REPEAT_PERIOD - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic [DEB_W-1:0] r_debCnt;
  logic [TMR_W-1:0] r_timer;
  logic             r_pulse;
  chan_state_e      r_state;

  logic w_debSat;
  logic w_timerSat;

  assign w_debSat   = &r_debCnt;
  assign w_timerSat = &r_timer;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Any cycle where the synchronized input agrees with stable restarts the count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stable <= 1'b0;
      r_debCnt <= '0;
    end else if (r_sync2 == r_stable) begin
      r_debCnt <= '0;
    end else if (r_debCnt == DEB_LAST) begin
      r_stable <= r_sync2;
      r_debCnt <= '0;
    end else if (!w_debSat) begin
      r_debCnt <= r_debCnt + DEB_W'(1);
    end
  end

  // IDLE only ever sees stable high right after a 0->1 update, so that is the press.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_timer <= '0;
          if (r_stable) begin
            r_pulse <= 1'b1;
            r_state <= ST_HELD;
          end
        end
        ST_HELD: begin
          if (!r_stable) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
          end else if (!i_repeat_en) begin
            r_timer <= '0;
          end else if (r_timer == DELAY_LAST) begin
            r_pulse <= 1'b1;
            r_timer <= '0;
            r_state <= ST_REPEAT;
          end else if (!w_timerSat) begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        ST_REPEAT: begin
          if (!r_stable) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
          end else if (!i_repeat_en) begin
            r_state <= ST_HELD;
            r_timer <= '0;
          end else if (r_timer == PERIOD_LAST) begin
            r_pulse <= 1'b1;
            r_timer <= '0;
          end else if (!w_timerSat) begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_timer <= '0;
        end
      endcase
    end
  end

  assign o_level = r_stable;
  assign o_pulse = r_pulse;

endmodule

// File: rtl/key_pulse_gen.sv
// Button front end: one key_channel per key plus the combined any_pulse,
// which is the OR of the channel pulse flops and so changes with them.
module key_pulse_gen
  import key_pulse_gen_pkg::*;
#(
  parameter int KEYS            = 5,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic            i_sys_clk,
  input  logic            i_sys_rst_n,
  input  logic [KEYS-1:0] i_key_raw,
  input  logic [KEYS-1:0] i_repeat_en,
  output logic [KEYS-1:0] o_key_level,
  output logic [KEYS-1:0] o_key_pulse,
  output logic            o_any_pulse
);

  logic [KEYS-1:0] w_pulse;

  for (genvar k = 0; k < KEYS; k++) begin : gen_chan
    key_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_chan (
      .i_clk       (i_sys_clk),
      .i_rst_n     (i_sys_rst_n),
      .i_raw       (i_key_raw[k]),
      .i_repeat_en (i_repeat_en[k]),
      .o_level     (o_key_level[k]),
      .o_pulse     (w_pulse[k])
    );
  end

  assign o_key_pulse = w_pulse;
  assign o_any_pulse = |w_pulse;

endmodule

// File: tb/tb_key_pulse_gen.sv
// Self-checking bench for key_pulse_gen: directed scenarios with literal
// latencies, then randomized key activity against an event-level model.
module tb_key_pulse_gen;
  import key_pulse_gen_pkg::*;

  localparam int KEYS = 5;
  localparam int DEB  = 4;
  localparam int RD   = 10;
  localparam int RP   = 3;

  localparam int M_IDLE   = 0;
  localparam int M_DELAY  = 1;
  localparam int M_PERIOD = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [KEYS-1:0] key_raw = '0;
  logic [KEYS-1:0] repeat_en = '0;
  logic [KEYS-1:0] key_level;
  logic [KEYS-1:0] key_pulse;
  logic            any_pulse;

  int vectors = 0;
  int miscompares = 0;

  bit rawD1  [KEYS];
  bit rawD2  [KEYS];
  bit win    [KEYS][DEB];
  bit mLevel [KEYS];
  bit mPulse [KEYS];
  int mode   [KEYS];
  int anchor [KEYS];
  int edgeNo = 0;
  bit lvlPrev;
  bit allFlip;

  key_pulse_gen #(
    .KEYS            (KEYS),
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .i_sys_clk   (clk),
    .i_sys_rst_n (rst_n),
    .i_key_raw   (key_raw),
    .i_repeat_en (repeat_en),
    .o_key_level (key_level),
    .o_key_pulse (key_pulse),
    .o_any_pulse (any_pulse)
  );

  initial forever #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [KEYS-1:0] raw, input logic [KEYS-1:0] en);
    key_raw   = raw;
    repeat_en = en;
  endtask

  function automatic logic pick(input int sel, input int k);
    case (sel)
      0:       return key_level[k];
      1:       return key_pulse[k];
      default: return any_pulse;
    endcase
  endfunction

  // Negedges until the selected output equals value; -1 if the bound expires.
  task automatic countUntil(input int k, input int sel, input logic value, input int maxCycles, output int n);
    n = -1;
    for (int i = 1; i <= maxCycles; i++) begin
      @(negedge clk);
      if (pick(sel, k) === value) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic countPulses(input int k, input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (key_pulse[k] !== 1'b0) cnt++;
    end
  endtask

  // Reference: level flips once the last DEB synchronized samples all disagree
  // with it; pulses are scheduled by edge distance from the last press/repeat/disable.
  task modelReset();
    for (int k = 0; k < KEYS; k++) begin
      rawD1[k]  = 1'b0;
      rawD2[k]  = 1'b0;
      mLevel[k] = 1'b0;
      mPulse[k] = 1'b0;
      mode[k]   = M_IDLE;
      anchor[k] = 0;
      for (int j = 0; j < DEB; j++) win[k][j] = 1'b0;
    end
  endtask

  task modelStep();
    edgeNo++;
    for (int k = 0; k < KEYS; k++) begin
      lvlPrev = mLevel[k];
      for (int j = 0; j < DEB - 1; j++) win[k][j] = win[k][j+1];
      win[k][DEB-1] = rawD2[k];
      allFlip = 1'b1;
      for (int j = 0; j < DEB; j++) if (win[k][j] == lvlPrev) allFlip = 1'b0;
      if (allFlip) mLevel[k] = ~lvlPrev;
      rawD2[k] = rawD1[k];
      rawD1[k] = key_raw[k];
      mPulse[k] = 1'b0;
      if (mode[k] == M_IDLE) begin
        if (lvlPrev) begin
          mPulse[k] = 1'b1;
          mode[k]   = M_DELAY;
          anchor[k] = edgeNo;
        end
      end else if (!lvlPrev) begin
        mode[k] = M_IDLE;
      end else if (!repeat_en[k]) begin
        mode[k]   = M_DELAY;
        anchor[k] = edgeNo;
      end else if (edgeNo - anchor[k] == ((mode[k] == M_DELAY) ? RD : RP)) begin
        mPulse[k] = 1'b1;
        mode[k]   = M_PERIOD;
        anchor[k] = edgeNo;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) modelReset();
    else modelStep();
  end

  initial begin : compare
    logic [KEYS-1:0] expLevel;
    logic [KEYS-1:0] expPulse;
    forever begin
      @(negedge clk);
      for (int k = 0; k < KEYS; k++) begin
        expLevel[k] = mLevel[k];
        expPulse[k] = mPulse[k];
      end
      checkOutput("cycle", {21'b0, key_level, key_pulse, any_pulse},
                  {21'b0, expLevel, expPulse, |expPulse});
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stim
    int n;
    int cnt;
    int bounceLen [4];
    logic [KEYS-1:0] nextRaw;
    logic [KEYS-1:0] nextEn;
    bounceLen = '{3, 1, 2, 5};

    applyStimulus('0, '0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] idle after reset");
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (key_level !== '0 || key_pulse !== '0 || any_pulse !== 1'b0) cnt++;
    end
    checkOutput("idle_quiet", cnt, 0);

    $display("[TB] single press, no repeat");
    @(negedge clk);
    applyStimulus(KEYS'(1 << KEY_UP), '0);
    countUntil(KEY_UP, 0, 1'b1, 20, n);
    checkOutput("press_level_latency", n, 6);
    countUntil(KEY_UP, 1, 1'b1, 5, n);
    checkOutput("press_pulse_latency", n, 1);
    countPulses(KEY_UP, 23, cnt);
    checkOutput("held_no_repeat", cnt, 0);
    applyStimulus('0, '0);
    countUntil(KEY_UP, 0, 1'b0, 20, n);
    checkOutput("release_level_latency", n, 6);
    countPulses(KEY_UP, 10, cnt);
    checkOutput("release_no_pulse", cnt, 0);

    $display("[TB] bounce rejection");
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus((i % 2 == 0) ? KEYS'(1 << KEY_LEFT) : '0, '0);
      repeat (bounceLen[i]) begin
        @(negedge clk);
        if (key_level[KEY_LEFT] !== 1'b0 || key_pulse[KEY_LEFT] !== 1'b0) cnt++;
      end
    end
    repeat (10) begin
      @(negedge clk);
      if (key_level[KEY_LEFT] !== 1'b0 || key_pulse[KEY_LEFT] !== 1'b0) cnt++;
    end
    checkOutput("bounce_rejected", cnt, 0);

    $display("[TB] auto-repeat");
    applyStimulus('0, KEYS'(1 << KEY_RIGHT));
    @(negedge clk);
    applyStimulus(KEYS'(1 << KEY_RIGHT), KEYS'(1 << KEY_RIGHT));
    countUntil(KEY_RIGHT, 1, 1'b1, 20, n);
    checkOutput("repeat_press_latency", n, 7);
    countUntil(KEY_RIGHT, 1, 1'b1, 20, n);
    checkOutput("first_repeat_gap", n, RD);
    countUntil(KEY_RIGHT, 1, 1'b1, 20, n);
    checkOutput("second_repeat_gap", n, RP);
    countUntil(KEY_RIGHT, 1, 1'b1, 20, n);
    checkOutput("third_repeat_gap", n, RP);
    repeat (17) @(negedge clk);
    applyStimulus('0, KEYS'(1 << KEY_RIGHT));
    countUntil(KEY_RIGHT, 0, 1'b0, 20, n);
    checkOutput("repeat_release_latency", n, 6);
    countPulses(KEY_RIGHT, 15, cnt);
    checkOutput("no_pulse_after_release", cnt, 0);
    applyStimulus('0, '0);

    $display("[TB] simultaneous presses");
    repeat (5) @(negedge clk);
    applyStimulus(KEYS'((1 << KEY_UP) | (1 << KEY_EXIT)), '0);
    countUntil(0, 2, 1'b1, 20, n);
    checkOutput("simul_any_latency", n, 7);
    checkOutput("simul_pulse_vector", {key_pulse, any_pulse}, 6'b100011);
    repeat (5) @(negedge clk);
    applyStimulus('0, '0);
    repeat (10) @(negedge clk);

    $display("[TB] reset during repeat");
    applyStimulus(KEYS'(1 << KEY_DOWN), KEYS'(1 << KEY_DOWN));
    repeat (19) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 checkOutput("async_reset_clear", {key_level, key_pulse, any_pulse}, 0);
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (key_level !== '0 || key_pulse !== '0 || any_pulse !== 1'b0) cnt++;
    end
    checkOutput("quiet_in_reset", cnt, 0);
    #1 rst_n = 1'b1;
    countUntil(KEY_DOWN, 1, 1'b1, 20, n);
    checkOutput("post_reset_press", n, 7);
    applyStimulus('0, '0);
    repeat (15) @(negedge clk);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      nextRaw = key_raw;
      nextEn  = repeat_en;
      for (int k = 0; k < KEYS; k++) begin
        if ($urandom_range(11) == 0) nextRaw[k] = ~nextRaw[k];
        if ($urandom_range(59) == 0) nextEn[k] = ~nextEn[k];
      end
      applyStimulus(nextRaw, nextEn);
      if (c == 1500) #1 rst_n = 1'b0;
      if (c == 1503) #1 rst_n = 1'b1;
    end
    applyStimulus('0, '0);
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
